// File: rtl/distance_requester_pkg.sv
`default_nettype none
// ============================================================================
// Module   : distance_requester_pkg
// Purpose  : Shared types and constants for the distance requester.
//            - state_e       : requester FSM states
//            - timer_width() : width of a saturating counter reaching a limit
//            - c_ERR_*       : encoding of the out_err flag
// Revision : 1.0 - initial release
// ============================================================================
package distance_requester_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_HI  = 3'd1,
    WAIT_CLR  = 3'd2,
    WAIT_DONE = 3'd3,
    RESULT    = 3'd4
  } state_e;

  // Bits needed to hold every value 0..limit (a limit of 0 still needs 1 bit).
  function automatic int unsigned timer_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

  localparam logic c_ERR_NONE    = 1'b0;
  localparam logic c_ERR_TIMEOUT = 1'b1;

endpackage : distance_requester_pkg
`default_nettype wire

// File: rtl/distance_requester_req_timer.sv
`default_nettype none
// ============================================================================
// Module   : req_timer
// Purpose  : Saturating up-counter with synchronous clear and enable.
//            reach_o flags the edge on which the count will land on LIMIT,
//            expired_o flags a count already sitting at LIMIT.
// Ports    : clk       - clock
//            reset     - asynchronous active-high reset (count -> 0)
//            clr_i     - clear count to 0 (wins over en_i)
//            en_i      - count one step this cycle
//            reach_o   - this enabled step brings the count to LIMIT
//            expired_o - count equals LIMIT
// Revision : 1.0 - initial release
// ============================================================================
module req_timer
  import distance_requester_pkg::*;
#(
  parameter int unsigned LIMIT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic reach_o,
  output logic expired_o
);

  localparam int unsigned W = timer_width(LIMIT);
  localparam logic [W-1:0] c_LIMIT = W'(LIMIT);
  localparam logic [W-1:0] c_LAST  = W'(LIMIT - 1);
  localparam logic [W-1:0] c_ONE   = W'(1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Saturate at LIMIT so a stuck enable can never wrap back to a small count.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != c_LIMIT)) begin
      count_d = count_q + c_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign reach_o   = en_i && !clr_i && (count_q == c_LAST);
  assign expired_o = (count_q == c_LIMIT);

endmodule : req_timer
`default_nettype wire

// File: rtl/distance_requester.sv
`default_nettype none
// ============================================================================
// Module   : distance_requester
// Purpose  : Initiator side of the distance engine start/done handshake.
//            Takes one operand from a valid/ready stream, presents it on
//            x_out, pulses s_out for START_LEN cycles, waits for the engine
//            to clear and then raise done_in, and returns the captured
//            distance (or a timeout error) on a valid/ready stream.
// Ports    : clk, reset          - clock, async active-high reset
//            in_valid/in_ready   - operand handshake, in_data operand
//            x_out, s_out        - operand bus and start to the engine
//            done_in, dist_in    - engine completion flag and result
//            out_valid/out_ready - result handshake
//            out_data, out_err   - captured distance, timeout flag
//            busy                - requester not idle
// Revision : 1.0 - initial release
// ============================================================================
module distance_requester
  import distance_requester_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned RES_W     = 32,
  parameter int unsigned START_LEN = 2,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] x_out,
  output logic              s_out,
  input  logic              done_in,
  input  logic [RES_W-1:0]  dist_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_data,
  output logic              out_err,
  output logic              busy
);

  state_e              state_q;
  logic                s_q;
  logic                valid_q;
  logic                err_q;
  logic [DATA_W-1:0]   x_q;
  logic [RES_W-1:0]    data_q;

  logic w_idle;
  logic w_start_en;
  logic w_wait_en;
  logic w_start_reach;
  logic w_start_exp;
  logic w_wait_reach;
  logic w_wait_exp;
  logic w_start_over;
  logic w_timed_out;

  assign w_idle     = (state_q == IDLE);
  assign w_start_en = (state_q == START_HI);
  assign w_wait_en  = (state_q == WAIT_CLR) || (state_q == WAIT_DONE);

  // Both counters are held clear while idle, so they start from 0 at accept.
  req_timer #(
    .LIMIT (START_LEN)
  ) u_start_cnt (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (w_idle),
    .en_i      (w_start_en),
    .reach_o   (w_start_reach),
    .expired_o (w_start_exp)
  );

  // Counts every cycle spent in WAIT_CLR and WAIT_DONE together.
  req_timer #(
    .LIMIT (TIMEOUT)
  ) u_wait_tmr (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (w_idle),
    .en_i      (w_wait_en),
    .reach_o   (w_wait_reach),
    .expired_o (w_wait_exp)
  );

  // expired_* cannot normally be seen in these states; included so a
  // saturated counter can never strand the FSM.
  assign w_start_over = w_start_reach || w_start_exp;
  assign w_timed_out  = w_wait_reach || w_wait_exp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      x_q     <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= c_ERR_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          // done_in is deliberately ignored here: a stale done is legal.
          if (in_valid) begin
            x_q     <= in_data;
            s_q     <= 1'b1;
            state_q <= START_HI;
          end
        end
        START_HI: begin
          if (w_start_over) begin
            s_q     <= 1'b0;
            state_q <= WAIT_CLR;
          end
        end
        WAIT_CLR: begin
          // A done still high here belongs to the previous run; wait for the
          // engine to drop it before trusting the next rising level.
          if (w_timed_out) begin
            data_q  <= '0;
            err_q   <= c_ERR_TIMEOUT;
            valid_q <= 1'b1;
            state_q <= RESULT;
          end else if (!done_in) begin
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // done takes priority over a timeout landing on the same edge.
          if (done_in) begin
            data_q  <= dist_in;
            err_q   <= c_ERR_NONE;
            valid_q <= 1'b1;
            state_q <= RESULT;
          end else if (w_timed_out) begin
            data_q  <= '0;
            err_q   <= c_ERR_TIMEOUT;
            valid_q <= 1'b1;
            state_q <= RESULT;
          end
        end
        RESULT: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          s_q     <= 1'b0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = w_idle;
  assign busy      = !w_idle;
  assign s_out     = s_q;
  assign x_out     = x_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_err   = err_q;

endmodule : distance_requester
`default_nettype wire

// File: tb/tb_distance_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_distance_requester
// Purpose  : Self-checking bench for distance_requester (START_LEN=2,
//            TIMEOUT=20). An engine waveform is chosen per request (stale
//            done level, cycle at which done clears, cycle at which it sets)
//            and the expected outcome is derived from that waveform alone.
// Revision : 1.0 - initial release
// ============================================================================
module tb_distance_requester;

  localparam int DATA_W    = 16;
  localparam int RES_W     = 32;
  localparam int START_LEN = 2;
  localparam int TIMEOUT   = 20;
  localparam int NEVER     = 1000;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [DATA_W-1:0] x_out;
  logic              s_out;
  logic              done_in = 1'b0;
  logic [RES_W-1:0]  dist_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [RES_W-1:0]  out_data;
  logic              out_err;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] last_x = '0;

  always #5 clk = ~clk;

  distance_requester #(
    .DATA_W    (DATA_W),
    .RES_W     (RES_W),
    .START_LEN (START_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .x_out     (x_out),
    .s_out     (s_out),
    .done_in   (done_in),
    .dist_in   (dist_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Engine done level during wait cycle w (w=0 is the first cycle after s falls).
  function automatic bit done_at(input bit sd, input int clr, input int set, input int w);
    if (w < clr) return sd;
    return (w >= set);
  endfunction

  // Outcome from the waveform: done must first be seen low, then high, all
  // within TIMEOUT wait cycles; a clear on the very last cycle is too late,
  // a set on the very last cycle still counts.
  function automatic void predict(input bit sd, input int clr, input int set,
                                  output int w_end, output bit err);
    int clear_w;
    clear_w = -1;
    w_end   = TIMEOUT - 1;
    err     = 1'b1;
    for (int w = 0; w <= TIMEOUT - 2; w++) begin
      if (clear_w < 0 && !done_at(sd, clr, set, w)) clear_w = w;
    end
    if (clear_w >= 0) begin
      for (int w = TIMEOUT - 1; w > clear_w; w--) begin
        if (done_at(sd, clr, set, w)) begin
          w_end = w;
          err   = 1'b0;
        end
      end
    end
  endfunction

  // Starts at a negedge with the DUT idle; ends at the negedge after the
  // result handshake, with the DUT idle again.
  task automatic run_txn(input logic [DATA_W-1:0] data, input bit sd, input int clr,
                         input int gap, input logic [RES_W-1:0] old_dist,
                         input logic [RES_W-1:0] new_dist, input int bp,
                         input logic [DATA_W-1:0] junk, input bit junk_always);
    int set;
    int w_end;
    bit err;
    int rise_c;
    logic [RES_W-1:0] exp_data;
    set = clr + gap;
    predict(sd, clr, set, w_end, err);
    rise_c   = START_LEN + 2 + w_end;
    exp_data = err ? '0 : new_dist;

    check_eq("idle_in_ready", in_ready, 1);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_out_valid", out_valid, 0);
    check_eq("idle_x_hold", x_out, last_x);
    in_valid  = 1'b1;
    in_data   = data;
    done_in   = sd;
    dist_in   = old_dist;
    out_ready = 1'($urandom_range(0, 1));

    for (int c = 1; c <= rise_c + bp; c++) begin
      @(negedge clk);
      check_eq("s_out", s_out, (c <= START_LEN));
      check_eq("busy_in_ready", in_ready, 0);
      check_eq("busy", busy, 1);
      check_eq("x_out", x_out, data);
      check_eq("out_valid", out_valid, (c >= rise_c));
      if (c >= rise_c) begin
        check_eq("out_data", out_data, exp_data);
        check_eq("out_err", out_err, err);
      end
      in_valid = junk_always | 1'($urandom_range(0, 1));
      in_data  = junk;
      if (c <= START_LEN) begin
        done_in = sd;
        dist_in = old_dist;
      end else begin
        done_in = done_at(sd, clr, set, c - START_LEN - 1);
        dist_in = ((c - START_LEN - 1) >= set) ? new_dist : old_dist;
      end
      if (c >= rise_c) out_ready = ((c - rise_c) >= bp);
      else             out_ready = 1'($urandom_range(0, 1));
    end

    @(negedge clk);
    check_eq("ret_out_valid", out_valid, 0);
    check_eq("ret_in_ready", in_ready, 1);
    check_eq("ret_x_hold", x_out, data);
    last_x    = data;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  // Accept an operand, advance to cycle at_c, then reset between edges.
  task automatic reset_mid(input logic [DATA_W-1:0] data, input int at_c);
    in_valid = 1'b1;
    in_data  = data;
    done_in  = 1'b1;
    dist_in  = 32'h0000_1234;
    for (int c = 1; c <= at_c; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      done_in  = (c <= START_LEN);
    end
    check_eq("pre_rst_busy", busy, 1);
    check_eq("pre_rst_s_out", s_out, (at_c <= START_LEN));
    done_in = 1'b1;
    dist_in = 32'h0000_0099;
    #2 reset = 1'b1;
    #1;
    check_eq("rst_s_out", s_out, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_x_out", x_out, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check_eq("post_rst_out_valid", out_valid, 0);
      check_eq("post_rst_busy", busy, 0);
    end
    last_x = '0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    check_eq("reset_in_ready", in_ready, 1);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_s_out", s_out, 0);
    check_eq("reset_out_valid", out_valid, 0);
    check_eq("reset_out_data", out_data, 0);
    check_eq("reset_out_err", out_err, 0);
    check_eq("reset_x_out", x_out, 0);
    @(negedge clk);
    check_eq("reset_edge_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);

    // Normal run: done drops 2 cycles after s falls, rises 8 cycles later.
    run_txn(16'h0005, 1'b1, 2, 8, 32'h0000_0000, 32'h0000_1234, 0, 16'h0000, 1'b0);
    // Stale done from the previous run must not be captured.
    run_txn(16'h0011, 1'b1, 3, 5, 32'h0000_1234, 32'h0000_BEEF, 1, 16'h0022, 1'b0);
    // Timeouts: done never clears, then done clears but never sets.
    run_txn(16'h0033, 1'b1, NEVER, 1, 32'h0000_1234, 32'h0000_5555, 0, 16'h0044, 1'b0);
    run_txn(16'h0055, 1'b1, 1, NEVER, 32'h0000_1234, 32'h0000_5555, 0, 16'h0066, 1'b0);
    // Clear arriving on the last wait cycle is too late.
    run_txn(16'h0057, 1'b1, TIMEOUT - 1, 1, 32'h0000_1234, 32'h0000_5555, 0, 16'h0000, 1'b0);
    // Backpressure with an operand offered throughout, then taken at once.
    run_txn(16'h0077, 1'b0, 0, 4, 32'h0000_0000, 32'h0000_ABCD, 5, 16'h0007, 1'b1);
    run_txn(16'h0007, 1'b1, 2, 3, 32'h0000_ABCD, 32'h0000_0101, 0, 16'h0000, 1'b0);
    // Done on the timeout cycle wins; one cycle later it is too late.
    run_txn(16'h0088, 1'b1, 5, TIMEOUT - 1 - 5, 32'h0000_0101, 32'h0000_0042, 0, 16'h0000, 1'b0);
    run_txn(16'h0099, 1'b1, 5, TIMEOUT - 5, 32'h0000_0101, 32'h0000_0043, 0, 16'h0000, 1'b0);

    // Asynchronous reset in WAIT_DONE and in START_HI.
    reset_mid(16'h00AA, 6);
    reset_mid(16'h00BB, 1);

    for (int i = 0; i < 40; i++) begin
      run_txn(16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 24),
              $urandom_range(1, 24), $urandom, $urandom, $urandom_range(0, 3),
              16'($urandom), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule : tb_distance_requester
`default_nettype wire

// File: doc/distance_requester.md
Name: distance_requester

Overview:
- Initiator side of the start/done handshake used by the iterative distance engine.
- Accepts one operand at a time on a valid/ready input stream and holds it on the engine operand bus.
- Issues the start pulse that the engine's control unit expects (s high, then s low), waits for done, and captures the distance result.
- Returns the result, with a timeout error flag, on a valid/ready output stream. Sits between the upstream sample source and the engine.

Parameters:
- DATA_W, 16, operand width driven to the engine.
- RES_W, 32, distance result width.
- START_LEN, 2, cycles s_out is held high per request (>=1).
- TIMEOUT, 1023, max cycles spent in WAIT_CLR+WAIT_DONE before abort (>=2).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand offered.
- in_ready  out  1  requester can accept an operand.
- in_data  in  DATA_W  operand.
- x_out  out  DATA_W  latched operand to engine, stable from accept until return to IDLE.
- s_out  out  1  engine start.
- done_in  in  1  engine done flag (level; cleared by engine at run start, set at completion).
- dist_in  in  RES_W  engine distance register, valid while done_in=1.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  RES_W  captured distance (0 on error).
- out_err  out  1  result is a timeout abort.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: state=IDLE, s_out=0, x_out=0, out_valid=0, out_data=0, out_err=0, timer=0. Therefore in_ready=1 and busy=0 during reset.
- in_ready = (state==IDLE), combinational from state. All other outputs are registered or decoded from state.
- IDLE:
  - in_valid=1 at an edge latches in_data into x_out, clears the timer and the start count, and moves to START_HI.
  - done_in is ignored in IDLE; a stale done is legal.
- START_HI:
  - s_out=1 for exactly START_LEN cycles, counted by a start counter.
  - After START_LEN cycles, moves to WAIT_CLR.
- WAIT_CLR:
  - s_out=0. The timer increments every cycle.
  - done_in=0 moves to WAIT_DONE. This rejects the previous run's done, which stays high until the engine starts a new run.
- WAIT_DONE:
  - The timer keeps incrementing.
  - done_in=1 captures dist_in into out_data, sets out_err=0, and moves to RESULT.
- Timeout:
  - If the timer reaches TIMEOUT in WAIT_CLR or WAIT_DONE, move to RESULT with out_data=0 and out_err=1.
  - If done_in=1 in WAIT_DONE on the same cycle the timer reaches TIMEOUT, done wins (valid capture).
- RESULT:
  - out_valid=1. out_data and out_err are held stable.
  - out_ready=1 at an edge moves to IDLE and drops out_valid.
  - in_valid is ignored in RESULT. A new operand is accepted no earlier than the cycle after the result handshake; there is no same-cycle turnaround.
- Latency: accept at edge k gives s_out=1 in cycles k+1..k+START_LEN. out_valid rises one cycle after the edge that samples done_in=1 in WAIT_DONE.
- Timer width: $clog2(TIMEOUT+1). It saturates and never wraps.
- Reset mid-operation: asynchronous return to the reset values in all states. s_out drops immediately. Any captured result is discarded. Engine reset is separate and not driven here.
- x_out is not cleared on leaving RESULT; it holds the last operand.

Decomposition:
- Shared package holds:
  - state enum {IDLE, START_HI, WAIT_CLR, WAIT_DONE, RESULT};
  - the timer-width function/localparam;
  - the error-encoding constant for out_err.
- One natural sub-module: req_timer.
  - Parameterised saturating counter with clear, enable and an expired flag at TIMEOUT.
  - Reused for the START_LEN count via a second instance with limit START_LEN.

Test Plan:
1. Normal run (START_LEN=2, TIMEOUT=20):
   - Stimulus: in_data=0x0005. Engine model drops done 2 cycles after s falls, raises done 8 cycles later with dist=0x00001234.
   - Response: s_out high exactly 2 cycles; x_out=0x0005; out_valid with out_data=0x00001234, out_err=0; in_ready=0 throughout.
2. Stale done:
   - Stimulus: done_in=1 left from the previous run (dist=0x00001234) at accept; engine clears done and later sets it with dist=0x0000BEEF.
   - Response: out_data=0x0000BEEF, never 0x00001234.
3. Timeout:
   - Stimulus: engine never clears done.
   - Response: out_valid rises after exactly 20 cycles in WAIT_CLR with out_err=1, out_data=0. Repeat with done cleared but never set: same result.
4. Backpressure:
   - Stimulus: out_ready=0 for 5 cycles in RESULT while in_valid=1 with in_data=0x0007.
   - Response: out_valid/out_data stable, in_ready=0, operand not taken. After out_ready=1, IDLE, then 0x0007 is accepted on the next edge.
5. Reset mid-WAIT_DONE:
   - Stimulus: assert reset asynchronously.
   - Response: s_out=0, out_valid=0, in_ready=1, busy=0 before the next clock edge; no result is emitted after release.
6. Done on timeout cycle:
   - Stimulus: done_in rises on the cycle the timer hits 20, with dist=0x00000042.
   - Response: out_err=0, out_data=0x00000042.
